cop_exec_unit: RTL and testbench



---
 rtl/cop_exec_unit.sv | 109 ++++++++++
 tb/tb_cop_exec_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cop_exec_unit.sv
// cop_exec_unit: coprocessor ALU with single-cycle ops and iterative mul/div.
module cop_exec_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED = 32'h0000_0001,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 32'h8020_0003
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [5:0] OP_ADD = 6'b110000;
  localparam logic [5:0] OP_SUB = 6'b110001;
  localparam logic [5:0] OP_MUL = 6'b110010;
  localparam logic [5:0] OP_DIV = 6'b110011;
  localparam logic [5:0] OP_CMP = 6'b110100;
  localparam logic [5:0] OP_REV = 6'b110101;
  localparam logic [5:0] OP_RND = 6'b110110;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  state_t state_q;
  logic [WIDTH-1:0] acc_q, shf_q, opd_q, lo_q, hi_q, lfsr_q;
  logic [WIDTH-1:0] acc_d, shf_d, rev_d, lfsr_d;
  logic [WIDTH:0] mul_sum, div_diff;
  logic [CW-1:0] cnt_q;
  logic busy_q, done_q, err_q;
  // acc holds partial product high / remainder, shf holds multiplier / quotient
  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, {WIDTH{shf_q[0]}} & opd_q};
    div_diff = {acc_q, shf_q[WIDTH-1]} - {1'b0, opd_q};
    acc_d = (state_q == S_MUL) ? mul_sum[WIDTH:1]
          : div_diff[WIDTH] ? {acc_q[WIDTH-2:0], shf_q[WIDTH-1]} : div_diff[WIDTH-1:0];
    shf_d = (state_q == S_MUL) ? {mul_sum[0], shf_q[WIDTH-1:1]}
          : {shf_q[WIDTH-2:0], ~div_diff[WIDTH]};
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    rev_d = '0;
    for (int i = 0; i < WIDTH; i++) rev_d[i] = op_a[WIDTH-1-i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      lfsr_q <= SEED_INIT;
      acc_q <= '0;
      shf_q <= '0;
      opd_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          done_q <= 1'b1;
          err_q <= 1'b0;
          cnt_q <= '0;
          acc_q <= '0;
          shf_q <= op_a;
          opd_q <= op_b;
          case (alu_op)
            OP_ADD: begin lo_q <= op_a + op_b; hi_q <= '0; end
            OP_SUB: begin lo_q <= op_a - op_b; hi_q <= '0; end
            OP_MUL: begin done_q <= 1'b0; busy_q <= 1'b1; state_q <= S_MUL; end
            OP_DIV:
              if (op_b == '0) begin
                lo_q <= '1;
                hi_q <= op_a;
                err_q <= 1'b1;
              end else begin
                done_q <= 1'b0;
                busy_q <= 1'b1;
                state_q <= S_DIV;
              end
            OP_CMP: begin lo_q <= WIDTH'({op_a == op_b, $signed(op_a) < $signed(op_b)}); hi_q <= '0; end
            OP_REV: begin lo_q <= rev_d; hi_q <= '0; end
            OP_RND: begin lo_q <= lfsr_q; hi_q <= '0; lfsr_q <= lfsr_d; end
            default: err_q <= 1'b1;
          endcase
        end
      end else begin
        acc_q <= acc_d;
        shf_q <= shf_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          hi_q <= acc_d;
          lo_q <= shf_d;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= S_IDLE;
        end
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
endmodule

// File: tb/tb_cop_exec_unit.sv
// tb_cop_exec_unit: directed and randomized checks of cop_exec_unit against a behavioural model.
module tb_cop_exec_unit;
  logic clk = 1'b0;
  logic reset, start, busy, done, err;
  logic [5:0] alu_op;
  logic [31:0] op_a, op_b, result_lo, result_hi;
  int checks = 0, errors = 0;
  logic [31:0] m_lo, m_hi, m_lfsr;
  logic m_err;
  int m_lat;
  always #5 clk = ~clk;
  cop_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .err(err), .result_lo(result_lo), .result_hi(result_hi)
  );
  // m_lat is the number of cycles after the accepting edge until done is seen
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    m_err = 1'b0;
    m_lat = 1;
    case (op)
      6'h30: begin m_lo = a + b; m_hi = 0; end
      6'h31: begin m_lo = a - b; m_hi = 0; end
      6'h32: begin p = 64'(a) * 64'(b); {m_hi, m_lo} = p; m_lat = 33; end
      6'h33:
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; m_err = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; m_lat = 33; end
      6'h34: begin m_lo = {30'b0, a == b, $signed(a) < $signed(b)}; m_hi = 0; end
      6'h35: begin m_lo = {<<{a}}; m_hi = 0; end
      6'h36: begin
        m_lo = m_lfsr;
        m_hi = 0;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
      end
      default: m_err = 1'b1;
    endcase
  endtask
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; alu_op = '0; op_a = '0; op_b = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_lo = 0; m_hi = 0; m_lfsr = 32'h1; m_err = 1'b0;
  endtask
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; alu_op = op; op_a = a; op_b = b;
    model(op, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask
  // scrambles operands every cycle; on cycle poke pulses an add start that must be ignored
  task automatic wait_done(input int poke, output int lat, output int bn);
    lat = -1;
    bn = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin lat = k; break; end
      bn += int'(busy);
      op_a = $urandom; op_b = $urandom;
      start = (k == poke);
      alu_op = start ? 6'h30 : 6'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, err, result_lo, result_hi} !== 67'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b err=%b lo=%h hi=%h expected all 0", busy, done, err, result_lo, result_hi);
    end
  endtask
  task automatic test_add();
    int lat, bn;
    issue(6'h30, 32'hFFFF_FFFF, 32'h2);
    wait_done(0, lat, bn);
    checks++;
    if (lat != 1 || bn != 0) begin errors++; $display("FAIL add_timing: lat %0d busy %0d expected 1/0", lat, bn); end
    checks++;
    if ({err, result_hi, result_lo} !== {1'b0, 32'h0, 32'h1}) begin
      errors++; $display("FAIL add_res: got %b/%h/%h expected 0/00000000/00000001", err, result_hi, result_lo);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, result_lo} !== {2'b00, 32'h1}) begin
      errors++; $display("FAIL add_hold: got done=%b busy=%b lo=%h expected 0/0/00000001", done, busy, result_lo);
    end
  endtask
  task automatic test_mul_ignore();
    int lat, bn;
    issue(6'h32, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(5, lat, bn);
    checks++;
    if (lat != 33 || bn != 32 || busy !== 1'b0) begin
      errors++; $display("FAIL mul_timing: lat %0d busy cycles %0d busy %b expected 33/32/0", lat, bn, busy);
    end
    checks++;
    if ({err, result_hi, result_lo} !== {1'b0, 32'hFFFF_FFFE, 32'h1}) begin
      errors++; $display("FAIL mul_res: got %b/%h/%h expected 0/fffffffe/00000001", err, result_hi, result_lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL mul_pulse: done %b expected 0", done); end
  endtask
  task automatic test_div();
    int lat, bn;
    issue(6'h33, 32'd100, 32'd7);
    wait_done(0, lat, bn);
    checks++;
    if (lat != 33 || {err, result_hi, result_lo} !== {1'b0, 32'd2, 32'd14}) begin
      errors++; $display("FAIL div_res: lat %0d got %b/%h/%h expected 33 0/2/e", lat, err, result_hi, result_lo);
    end
    issue(6'h33, 32'd5, 32'd0);
    wait_done(0, lat, bn);
    checks++;
    if (lat != 1 || bn != 0 || {err, result_hi, result_lo} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL div_zero: lat %0d got %b/%h/%h expected 1 1/5/ffffffff", lat, err, result_hi, result_lo);
    end
  endtask
  task automatic test_cmp_rev();
    int lat, bn;
    logic [5:0] ops [3] = '{6'h34, 6'h34, 6'h35};
    logic [31:0] as [3] = '{32'hFFFF_FFFE, 32'd9, 32'h1};
    logic [31:0] bs [3] = '{32'd3, 32'd9, 32'h1234_5678};
    logic [31:0] ex [3] = '{32'h1, 32'h2, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(0, lat, bn);
      checks++;
      if (lat != 1 || {err, result_hi, result_lo} !== {1'b0, 32'h0, ex[i]}) begin
        errors++; $display("FAIL cmp_rev[%0d]: lat %0d got %b/%h/%h expected 1 0/0/%h", i, lat, err, result_hi, result_lo, ex[i]);
      end
    end
  endtask
  task automatic test_rnd();
    int lat, bn;
    logic [31:0] ex [3] = '{32'h1, 32'h8020_0003, 32'hC030_0002};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(6'h36, $urandom, $urandom);
      wait_done(0, lat, bn);
      checks++;
      if (lat != 1 || {err, result_lo} !== {1'b0, ex[i]}) begin
        errors++; $display("FAIL rnd[%0d]: lat %0d got %b/%h expected 0/%h", i, lat, err, result_lo, ex[i]);
      end
    end
    issue(6'b001000, 32'h55, 32'hAA);
    wait_done(0, lat, bn);
    checks++;
    if (lat != 1 || {err, result_hi, result_lo} !== {1'b1, 32'h0, 32'hC030_0002}) begin
      errors++; $display("FAIL bad_op: lat %0d got %b/%h/%h expected 1 1/0/c0300002", lat, err, result_hi, result_lo);
    end
  endtask
  task automatic test_reset_abort();
    int lat, bn;
    logic saw;
    issue(6'h32, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_lo = 0; m_hi = 0; m_lfsr = 32'h1;
    checks++;
    if ({busy, done, err, result_lo, result_hi} !== 67'h0) begin
      errors++; $display("FAIL abort_reset: got busy=%b done=%b err=%b lo=%h hi=%h expected all 0", busy, done, err, result_lo, result_hi);
    end
    saw = 1'b0;
    repeat (40) begin @(negedge clk); saw |= done | busy; end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL abort_quiet: got done/busy activity %b expected 0", saw); end
    issue(6'h30, 32'd3, 32'd4);
    wait_done(0, lat, bn);
    checks++;
    if (lat != 1 || {err, result_hi, result_lo} !== {1'b0, 32'h0, 32'd7}) begin
      errors++; $display("FAIL abort_add: lat %0d got %b/%h/%h expected 1 0/0/7", lat, err, result_hi, result_lo);
    end
  endtask
  task automatic test_back_to_back();
    int lat, bn;
    logic [5:0] ops [6] = '{6'h30, 6'h32, 6'h31, 6'h33, 6'h36, 6'h32};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], $urandom, $urandom_range(1, 1000));
      wait_done(0, lat, bn);
      checks++;
      if (lat != m_lat || {err, result_hi, result_lo} !== {m_err, m_hi, m_lo}) begin
        errors++; $display("FAIL b2b[%0d]: lat %0d got %b/%h/%h expected %0d %b/%h/%h",
                           i, lat, err, result_hi, result_lo, m_lat, m_err, m_hi, m_lo);
      end
    end
  endtask
  task automatic test_random();
    int lat, bn, sel;
    logic [5:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 8);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      op = (sel < 7) ? 6'(6'h30 + sel) : (sel == 7) ? 6'($urandom_range(0, 47)) : 6'h33;
      issue(op, a, b);
      wait_done(0, lat, bn);
      checks++;
      if ({err, result_hi, result_lo} !== {m_err, m_hi, m_lo}) begin
        errors++; $display("FAIL rand_res op=%h a=%h b=%h: got %b/%h/%h expected %b/%h/%h",
                           op, a, b, err, result_hi, result_lo, m_err, m_hi, m_lo);
      end
      checks++;
      if (lat != m_lat || bn != m_lat - 1 || busy !== 1'b0) begin
        errors++; $display("FAIL rand_timing op=%h: lat %0d busy cycles %0d expected %0d/%0d", op, lat, bn, m_lat, m_lat - 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_mul_ignore();
    test_div();
    test_cmp_rev();
    test_rnd();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
